// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// The multiply uses a fixed latency of MUL_CYCLES. The divide is restoring radix-2 and
// produces one quotient bit per cycle. Division by zero and signed overflow take a
// one-cycle fast path. Valid/ready handshakes sit on both the request and result sides.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W    = $clog2(XLEN + 1);
  localparam int unsigned PW       = 2 * XLEN;
  localparam int unsigned DIV_LAST = XLEN - 1;
  localparam int unsigned MUL_LAST = (MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0;
  localparam logic [XLEN-1:0] MIN_INT = XLEN'(1) << (XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_mul_fin;
  logic              w_div_fin;

  // Multiplier operands: taken from the request in IDLE so that a 1-cycle multiply can
  // finish on the accept edge. Otherwise they come from the registered copies.
  logic [1:0]        w_mop;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic [PW-1:0]     w_a_ext;
  logic [PW-1:0]     w_b_ext;
  logic [PW-1:0]     w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mop     = (r_state == S_IDLE) ? funct3[1:0] : r_op;
  assign w_ma      = (r_state == S_IDLE) ? rs1_data : r_quo;
  assign w_mb      = (r_state == S_IDLE) ? rs2_data : r_div;
  assign w_a_ext   = {{XLEN{(w_mop != 2'b11) & w_ma[XLEN-1]}}, w_ma};
  assign w_b_ext   = {{XLEN{~w_mop[1] & w_mb[XLEN-1]}}, w_mb};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (w_mop == 2'b00) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];

  // Divide request decode: fast-path detection and operand magnitudes.
  logic              w_in_sgn;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;

  assign w_in_sgn   = ~funct3[0];
  assign w_div0     = (rs2_data == '0);
  assign w_ovf      = w_in_sgn & (rs1_data == MIN_INT) & (rs2_data == '1);
  assign w_fast     = w_div0 | w_ovf;
  assign w_fast_res = funct3[1] ? (w_div0 ? rs1_data : '0) : (w_div0 ? '1 : rs1_data);
  assign w_neg_a    = w_in_sgn & rs1_data[XLEN-1];
  assign w_neg_b    = w_in_sgn & rs2_data[XLEN-1];
  assign w_mag_a    = w_neg_a ? -rs1_data : rs1_data;
  assign w_mag_b    = w_neg_b ? -rs2_data : rs2_data;

  // One restoring step. The dividend shifts out of r_quo while quotient bits shift in.
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_div_res;

  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nxt = w_ge ? (w_rem_sh[XLEN-1:0] - r_div) : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                             : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and datapath strobes; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mul_fin   = 1'b0;
    w_div_fin   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_accept = 1'b1;
            if (!funct3[2])  w_state_nxt = (MUL_CYCLES < 2) ? S_DONE : S_MUL;
            else if (w_fast) w_state_nxt = S_DONE;
            else             w_state_nxt = S_DIV;
          end
        end
        S_MUL: begin
          if (r_cnt == CNT_W'(MUL_LAST)) begin
            w_mul_fin   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
        S_DIV: begin
          if (r_cnt == CNT_W'(DIV_LAST)) begin
            w_div_fin   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, divide iteration, result capture, output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= funct3[1:0];
            r_cnt <= '0;
            if (!funct3[2]) begin
              r_quo <= rs1_data;
              r_div <= rs2_data;
              if (MUL_CYCLES < 2) begin
                r_result    <= w_mul_res;
                r_out_valid <= 1'b1;
              end
            end else if (w_fast) begin
              r_result    <= w_fast_res;
              r_out_valid <= 1'b1;
            end else begin
              r_quo   <= w_mag_a;
              r_div   <= w_mag_b;
              r_rem   <= '0;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_mul_fin) begin
            r_result    <= w_mul_res;
            r_out_valid <= 1'b1;
          end
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_div_fin) begin
            r_result    <= w_div_res;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit (XLEN=32) against an arithmetic reference.
module tb_muldiv_unit;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MUL_CYCLES = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_err    = 0;

  muldiv_unit #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of an M-extension op, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Cycle, counted from the accept cycle, in which out_valid should first be seen.
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_CYCLES;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic wait_idle();
    int cyc = 0;
    while (!in_ready && cyc < 60) begin
      tick();
      cyc++;
    end
    check("idle_wait", 64'(in_ready), 64'(1));
  endtask

  // Issue one op. Random requests are driven while the unit is busy. After the result
  // appears, out_ready is held low for 'hold' cycles and then the result is accepted.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    int cyc;
    int lat_exp;
    lat_exp = ref_lat(f, a, b);
    wait_idle();
    in_valid = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    tick();
    check("busy_after_accept", 64'(in_ready), 64'(0));
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      funct3   = 3'($urandom);
      rs1_data = $urandom;
      rs2_data = $urandom;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check($sformatf("latency f%0d %h/%h", f, a, b), 64'(cyc), 64'(lat_exp));
    check($sformatf("result f%0d %h/%h", f, a, b), 64'(result), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", 64'(result), 64'(exp));
      check("hold_busy", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'(0));
    check("release_ready", 64'(in_ready), 64'(1));
  endtask

  // Start a long divide and abort it after n cycles with flush or rst.
  task automatic abort_div(input int n, input bit use_rst);
    int seen;
    wait_idle();
    in_valid = 1'b1;
    funct3   = 3'b100;
    rs1_data = 32'hFFFF_FFEC;
    rs2_data = 32'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < n; i++) tick();
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check(use_rst ? "rst_ready" : "flush_ready", 64'(in_ready), 64'(1));
    check(use_rst ? "rst_valid" : "flush_valid", 64'(out_valid), 64'(0));
    if (use_rst) check("rst_result", 64'(result), 64'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check(use_rst ? "rst_no_result" : "flush_no_result", 64'(seen), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          pick;

    repeat (3) tick();
    rst = 1'b0;
    check("reset_ready", 64'(in_ready), 64'(1));
    check("reset_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));

    // Directed cases with hand-computed expectations.
    run_op(3'b001, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 0);
    run_op(3'b000, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, 1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 10);
    run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 0);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 0);
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run_op(3'b111, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 0);

    // Abort mid-operation.
    abort_div(10, 1'b0);
    abort_div(5, 1'b1);

    // A flush in the same cycle as a request in IDLE drops the request.
    wait_idle();
    in_valid = 1'b1;
    flush    = 1'b1;
    funct3   = 3'b000;
    rs1_data = 32'd6;
    rs2_data = 32'd7;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_drop_ready", 64'(in_ready), 64'(1));
    repeat (3) tick();
    check("flush_drop_valid", 64'(out_valid), 64'(0));

    // The unit must still work after the aborts.
    run_op(3'b000, 32'd6, 32'd7, 32'd42, 0);

    // Randomized ops, biased toward divide corner cases.
    for (int n = 0; n < 150; n++) begin
      f    = 3'($urandom_range(0, 7));
      a    = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(f, a, b, ref_model(f, a, b), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
